rf_wport_sched: RTL and testbench
=================================

# rf_wport_sched

Write-port scheduler and scoreboard for the 32×32 pipeline register file (r0 hard-wired zero, single write port, two combinational read ports). It shares the one write port between the in-order WB stage and a multi-cycle multiply/divide unit (MDU) through a one-entry result buffer. It tracks which registers have an MDU result outstanding and stalls ID reads of those registers. It also requests a pipeline hold when the buffered MDU result is starved too long.

## Interface
- MAX_WAIT, 4, cycles a buffered MDU result may lose arbitration before hold_pipe asserts; legal 1..15
- clk  in  1  clock; all state updates on rising edge
- clrn  in  1  reset, active-low, synchronous
- pipe_we  in  1  WB-stage write enable
- pipe_wn  in  5  WB-stage destination register
- pipe_d  in  32  WB-stage write data
- iss_valid  in  1  MDU issue request (ID stage)
- iss_wn  in  5  MDU issue destination register
- iss_ready  out  1  issue accepted this cycle
- mdu_valid  in  1  MDU result valid
- mdu_wn  in  5  MDU result destination
- mdu_d  in  32  MDU result data
- mdu_ready  out  1  result accepted this cycle
- rs, rt  in  5 each  ID-stage source register numbers
- stall_a, stall_b  out  1 each  source rs / rt awaits an MDU result
- rf_we  out  1  to regfile we
- rf_wn  out  5  to regfile wn
- rf_d  out  32  to regfile d
- hold_pipe  out  1  request: pipeline presents no WB write next cycle
- err_waw  out  1  sticky: WB wrote a register with an outstanding MDU result

## Operation
- State: busy[31:1], buf_valid/buf_wn/buf_d, wait_cnt (4 bits), err_waw. All are cleared by reset.
- Write arbitration: pipe_act = pipe_we && pipe_wn != 0.
  - pipe_act is true: rf_we=1, rf_wn=pipe_wn, rf_d=pipe_d. The WB stage always wins.
  - else buf_valid is true: rf_we=1, rf_wn=buf_wn, rf_d=buf_d. This is a drain.
  - else rf_we=0, and rf_wn/rf_d are 0.
- Drain at the edge: clear buf_valid, clear busy[buf_wn], and set wait_cnt to 0.
- Result buffer: mdu_ready = clrn && !buf_valid.
  - Accept (mdu_valid && mdu_ready) with mdu_wn != 0 loads buf_valid=1, buf_wn, buf_d.
  - Accept with mdu_wn == 0 is consumed and discarded.
- Scoreboard: iss_ready = clrn && (iss_wn == 0 || !busy[iss_wn]).
  - Accept with iss_wn != 0 sets busy[iss_wn].
  - At most one outstanding result per register; multiple outstanding results to distinct registers are legal.
- Stalls: stall_a = rs != 0 && busy[rs]; stall_b is the same for rt. A stall remains asserted through the drain cycle and deasserts the cycle after the write lands.
- Starvation: while buf_valid && pipe_act, wait_cnt increments and saturates at MAX_WAIT. hold_pipe = buf_valid && wait_cnt == MAX_WAIT. If pipe_act persists despite hold_pipe, pipe still wins.
- err_waw: set at the edge when pipe_act && busy[pipe_wn]. The WB write proceeds and busy is unchanged. Only reset clears err_waw.

## Timing
- Reset: while clrn=0, rf_we=0, mdu_ready=0, iss_ready=0, stall_a=stall_b=0, hold_pipe=0. err_waw reads 0 from the first edge with clrn=0. Reset mid-operation drops the buffered result and all busy bits.
- Pipe write: zero latency, combinational to the regfile, written at the same edge.
- MDU result: accepted at edge N, on the port in cycle N+1 at the earliest, written at edge N+1.
- Back-to-back MDU results: one per 2 cycles at best. mdu_ready is low during the drain cycle.
- Issue and drain to the same register in the same cycle: iss_ready=0, because busy is still set. The issue is accepted the next cycle.
- Issue to register X and MDU result to a different register in the same cycle: both proceed independently.
- hold_pipe is combinational from registered state and is therefore glitch-free relative to inputs.

## Test plan
- Reset, then pipe_we=1, pipe_wn=5, pipe_d=0xA5A5A5A5 → rf_we=1, rf_wn=5, rf_d=0xA5A5A5A5 in the same cycle; pipe_wn=0 → rf_we=0.
- Issue iss_wn=8, then rs=8 → stall_a=1. mdu_valid with wn=8, d=0x1234 and the pipe idle → accepted, next cycle rf_wn=8/rf_d=0x1234, stall_a falls one cycle after the write.
- Buffer holds wn=3 while pipe_act for 4 consecutive cycles (MAX_WAIT=4) → hold_pipe=1 after the 4th. Pipe idle next → drain of r3, hold_pipe=0.
- Issue iss_wn=9 twice without a result → second iss_ready=0. iss_wn=0 → iss_ready=1 and no busy bit set. mdu_wn=0 result → accepted, no regfile write.
- busy[12] set, then pipe writes r12 → write occurs, err_waw=1 and stays 1 until clrn=0.
- clrn=0 for one cycle while buffer full and busy[4] set → buffer discarded, stall on rs=4 clears, mdu_ready=1 after release.

Source files
------------

// File: rtl/rf_wport_sched.sv
// rf_wport_sched: shares the register-file write port between the WB stage
// and a one-entry MDU result buffer. It keeps a busy scoreboard of registers
// with an MDU result outstanding and flags long starvation of the buffer.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. ready depends only on registered state and the request's own
// register number, never on valid. A requester holds its payload stable while
// valid is high and ready is low.
module rf_wport_sched #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_wn,
  input  logic [31:0] pipe_d,
  input  logic        iss_valid,
  input  logic [4:0]  iss_wn,
  output logic        iss_ready,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_wn,
  input  logic [31:0] mdu_d,
  output logic        mdu_ready,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  output logic        stall_a,
  output logic        stall_b,
  output logic        rf_we,
  output logic [4:0]  rf_wn,
  output logic [31:0] rf_d,
  output logic        hold_pipe,
  output logic        err_waw
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  // Bit 0 stays 0 so r0 never reads as busy.
  logic [31:0] busy_q, busy_d;
  logic        buf_valid_q, buf_valid_d;
  logic [4:0]  buf_wn_q, buf_wn_d;
  logic [31:0] buf_d_q, buf_d_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        err_waw_q, err_waw_d;

  logic pipe_act;
  logic drain;
  logic mdu_acc;
  logic iss_acc;

  // Write-port arbitration and handshake outputs; WB always has priority.
  always_comb begin
    pipe_act  = pipe_we && (pipe_wn != 5'd0);
    drain     = !pipe_act && buf_valid_q;
    mdu_ready = clrn && !buf_valid_q;
    iss_ready = clrn && ((iss_wn == 5'd0) || !busy_q[iss_wn]);
    mdu_acc   = mdu_valid && mdu_ready;
    iss_acc   = iss_valid && iss_ready;
    stall_a   = clrn && (rs != 5'd0) && busy_q[rs];
    stall_b   = clrn && (rt != 5'd0) && busy_q[rt];
    hold_pipe = clrn && buf_valid_q && (wait_cnt_q == MAX_W);
    err_waw   = err_waw_q;
    rf_we     = 1'b0;
    rf_wn     = 5'd0;
    rf_d      = 32'd0;
    if (clrn) begin
      if (pipe_act) begin
        rf_we = 1'b1;
        rf_wn = pipe_wn;
        rf_d  = pipe_d;
      end else if (buf_valid_q) begin
        rf_we = 1'b1;
        rf_wn = buf_wn_q;
        rf_d  = buf_d_q;
      end
    end
  end

  // Next-state for buffer, scoreboard, starvation counter and error flag.
  always_comb begin
    busy_d      = busy_q;
    buf_valid_d = buf_valid_q;
    buf_wn_d    = buf_wn_q;
    buf_d_d     = buf_d_q;
    wait_cnt_d  = wait_cnt_q;
    err_waw_d   = err_waw_q;
    if (pipe_act && busy_q[pipe_wn]) begin
      err_waw_d = 1'b1;
    end
    if (drain) begin
      buf_valid_d      = 1'b0;
      busy_d[buf_wn_q] = 1'b0;
      wait_cnt_d       = 4'd0;
    end else if (buf_valid_q && pipe_act && (wait_cnt_q != MAX_W)) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
    // A result for r0 is taken off the MDU but never buffered.
    if (mdu_acc && (mdu_wn != 5'd0)) begin
      buf_valid_d = 1'b1;
      buf_wn_d    = mdu_wn;
      buf_d_d     = mdu_d;
    end
    if (iss_acc && (iss_wn != 5'd0)) begin
      busy_d[iss_wn] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      busy_q      <= 32'd0;
      buf_valid_q <= 1'b0;
      buf_wn_q    <= 5'd0;
      buf_d_q     <= 32'd0;
      wait_cnt_q  <= 4'd0;
      err_waw_q   <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      buf_valid_q <= buf_valid_d;
      buf_wn_q    <= buf_wn_d;
      buf_d_q     <= buf_d_d;
      wait_cnt_q  <= wait_cnt_d;
      err_waw_q   <= err_waw_d;
    end
  end

endmodule

// File: tb/tb_rf_wport_sched.sv
// Bench for rf_wport_sched: directed steps then random traffic, every cycle
// compared against a behavioural model of the scoreboard and buffer.
module tb_rf_wport_sched;

  localparam int MAX_WAIT = 4;

  logic        clk;
  logic        clrn;
  logic        pipe_we;
  logic [4:0]  pipe_wn;
  logic [31:0] pipe_d;
  logic        iss_valid;
  logic [4:0]  iss_wn;
  logic        iss_ready;
  logic        mdu_valid;
  logic [4:0]  mdu_wn;
  logic [31:0] mdu_d;
  logic        mdu_ready;
  logic [4:0]  rs, rt;
  logic        stall_a, stall_b;
  logic        rf_we;
  logic [4:0]  rf_wn;
  logic [31:0] rf_d;
  logic        hold_pipe;
  logic        err_waw;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit          m_busy[32];
  bit          m_bv;
  logic [4:0]  m_bwn;
  logic [31:0] m_bd;
  int          m_cnt;
  bit          m_err;

  rf_wport_sched #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .clrn(clrn),
    .pipe_we(pipe_we), .pipe_wn(pipe_wn), .pipe_d(pipe_d),
    .iss_valid(iss_valid), .iss_wn(iss_wn), .iss_ready(iss_ready),
    .mdu_valid(mdu_valid), .mdu_wn(mdu_wn), .mdu_d(mdu_d), .mdu_ready(mdu_ready),
    .rs(rs), .rt(rt), .stall_a(stall_a), .stall_b(stall_b),
    .rf_we(rf_we), .rf_wn(rf_wn), .rf_d(rf_d),
    .hold_pipe(hold_pipe), .err_waw(err_waw)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_pipe_act();
    return pipe_we && (pipe_wn != 5'd0);
  endfunction

  function automatic bit m_iss_ready();
    return clrn && ((iss_wn == 5'd0) || !m_busy[iss_wn]);
  endfunction

  // Compare every DUT output against what the model says for this cycle.
  task automatic check_all();
    bit          pa;
    logic [4:0]  e_wn;
    logic [31:0] e_d;
    bit          e_we;
    #1;
    pa   = m_pipe_act();
    e_we = 0; e_wn = 0; e_d = 0;
    if (clrn && pa) begin
      e_we = 1; e_wn = pipe_wn; e_d = pipe_d;
    end else if (clrn && m_bv) begin
      e_we = 1; e_wn = m_bwn; e_d = m_bd;
    end
    chk("rf_we", 32'(rf_we), 32'(e_we));
    chk("rf_wn", 32'(rf_wn), 32'(e_wn));
    chk("rf_d", rf_d, e_d);
    chk("mdu_ready", 32'(mdu_ready), 32'(clrn && !m_bv));
    chk("iss_ready", 32'(iss_ready), 32'(m_iss_ready()));
    chk("stall_a", 32'(stall_a), 32'(clrn && rs != 0 && m_busy[rs]));
    chk("stall_b", 32'(stall_b), 32'(clrn && rt != 0 && m_busy[rt]));
    chk("hold_pipe", 32'(hold_pipe), 32'(clrn && m_bv && m_cnt == MAX_WAIT));
    chk("err_waw", 32'(err_waw), 32'(m_err));
  endtask

  // Apply the rules for one rising edge to the model.
  task automatic model_edge();
    bit pa, ir, bv_old;
    if (!clrn) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      m_bv = 0; m_bwn = 0; m_bd = 0; m_cnt = 0; m_err = 0;
      return;
    end
    pa     = m_pipe_act();
    ir     = m_iss_ready();
    bv_old = m_bv;
    if (pa && m_busy[pipe_wn]) m_err = 1;
    if (!pa && m_bv) begin
      m_busy[m_bwn] = 0;
      m_bv  = 0;
      m_cnt = 0;
    end else if (m_bv && pa) begin
      m_cnt = (m_cnt + 1 > MAX_WAIT) ? MAX_WAIT : m_cnt + 1;
    end
    if (mdu_valid && !bv_old && mdu_wn != 0) begin
      m_bv = 1; m_bwn = mdu_wn; m_bd = mdu_d;
    end
    if (iss_valid && ir && iss_wn != 0) m_busy[iss_wn] = 1;
  endtask

  task automatic cycle();
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    pipe_we = 0; pipe_wn = 0; pipe_d = 0;
    iss_valid = 0; iss_wn = 0;
    mdu_valid = 0; mdu_wn = 0; mdu_d = 0;
    rs = 0; rt = 0;
  endtask

  initial begin
    clrn = 0;
    idle_inputs();
    @(posedge clk);
    model_edge();
    #1;
    // Reset state.
    cycle();
    chk("reset_err_waw", 32'(err_waw), 32'd0);
    clrn = 1;
    cycle();

    // WB write is combinational to the port.
    pipe_we = 1; pipe_wn = 5; pipe_d = 32'hA5A5A5A5;
    #1;
    chk("pipe_rf_d_direct", rf_d, 32'hA5A5A5A5);
    cycle();
    pipe_wn = 0;
    cycle();
    idle_inputs();

    // Issue r8, stall on rs, result drains with pipe idle.
    iss_valid = 1; iss_wn = 8;
    cycle();
    iss_valid = 0; rs = 8;
    #1;
    chk("stall_a_direct", 32'(stall_a), 32'd1);
    cycle();
    mdu_valid = 1; mdu_wn = 8; mdu_d = 32'h1234;
    cycle();
    mdu_valid = 0;
    #1;
    chk("drain_rf_wn_direct", 32'(rf_wn), 32'd8);
    cycle();
    cycle();

    // Starvation of buffered r3.
    idle_inputs();
    iss_valid = 1; iss_wn = 3;
    cycle();
    iss_valid = 0;
    mdu_valid = 1; mdu_wn = 3; mdu_d = 32'h3333;
    pipe_we = 1; pipe_wn = 1; pipe_d = 32'h11;
    cycle();
    mdu_valid = 0;
    for (int i = 0; i < 4; i++) begin
      pipe_d = 32'(i);
      cycle();
    end
    #1;
    chk("hold_pipe_direct", 32'(hold_pipe), 32'd1);
    cycle();
    pipe_we = 0;
    cycle();
    cycle();

    // Double issue to r9, issue to r0, result to r0.
    iss_valid = 1; iss_wn = 9;
    cycle();
    cycle();
    iss_wn = 0;
    cycle();
    iss_valid = 0;
    mdu_valid = 1; mdu_wn = 0; mdu_d = 32'hDEAD;
    cycle();
    mdu_wn = 9; mdu_d = 32'h99;
    cycle();
    mdu_valid = 0;
    cycle();
    cycle();

    // WAW error on r12, sticky until reset.
    iss_valid = 1; iss_wn = 12;
    cycle();
    iss_valid = 0;
    pipe_we = 1; pipe_wn = 12; pipe_d = 32'hC0C0;
    cycle();
    pipe_we = 0;
    cycle();
    cycle();

    // Reset while buffer full and r4 busy; r12 is still busy too.
    iss_valid = 1; iss_wn = 4;
    cycle();
    iss_valid = 0;
    mdu_valid = 1; mdu_wn = 4; mdu_d = 32'h4444;
    pipe_we = 1; pipe_wn = 2; pipe_d = 32'h2;
    rs = 4;
    cycle();
    mdu_valid = 0;
    clrn = 0;
    cycle();
    clrn = 1;
    pipe_we = 0;
    cycle();
    cycle();

    // Random traffic; MDU results target outstanding registers only.
    for (int n = 0; n < 600; n++) begin
      int cand[$];
      clrn      = ($urandom_range(0, 149) != 0);
      pipe_we   = ($urandom_range(0, 9) < 6);
      if (m_bv && m_cnt == MAX_WAIT && $urandom_range(0, 3) != 0) pipe_we = 0;
      pipe_wn   = 5'($urandom_range(0, 31));
      pipe_d    = $urandom;
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_wn    = 5'($urandom_range(0, 31));
      rs        = 5'($urandom_range(0, 31));
      rt        = 5'($urandom_range(0, 31));
      cand.delete();
      for (int r = 1; r < 32; r++)
        if (m_busy[r] && !(m_bv && m_bwn == 5'(r))) cand.push_back(r);
      mdu_valid = 0; mdu_wn = 0; mdu_d = $urandom;
      if (cand.size() > 0 && $urandom_range(0, 2) == 0) begin
        mdu_valid = 1;
        mdu_wn    = 5'(cand[$urandom_range(0, cand.size() - 1)]);
      end else if ($urandom_range(0, 19) == 0) begin
        mdu_valid = 1;
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
